// File: rtl/seq_left_shifter.sv
// rtl/seq_left_shifter.sv - multi-cycle 16-bit left shifter/rotator, one barrel stage per clock
// Define SEQ_LSHIFT_ROTATE_EN to build the rotate path; otherwise Op is ignored (logical shift only).
module seq_left_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] In,
    input  logic [3:0]  Cnt,
    input  logic        Op,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] Out,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] data;
    logic [3:0]  cnt;
    logic        op;
    logic [1:0]  stage;
    logic        rot_en;
    logic [15:0] shifted;

`ifdef SEQ_LSHIFT_ROTATE_EN
    assign rot_en = op;
`else
    logic unused_op;
    assign rot_en    = 1'b0;
    assign unused_op = op;
`endif

    // Stage k shifts by 2^k; rotate wraps the bits pushed out of the top into the bottom.
    always_comb begin
        shifted = data;
        case (stage)
            2'd0: shifted = {data[14:0], rot_en ? data[15]    : 1'b0};
            2'd1: shifted = {data[13:0], rot_en ? data[15:14] : 2'b0};
            2'd2: shifted = {data[11:0], rot_en ? data[15:12] : 4'b0};
            default: shifted = {data[7:0], rot_en ? data[15:8] : 8'b0};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (stage == 2'd3) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= 16'h0000;
            cnt   <= 4'd0;
            op    <= 1'b0;
            stage <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data  <= In;
                        cnt   <= Cnt;
                        op    <= Op;
                        stage <= 2'd0;
                    end
                end
                BUSY: begin
                    if (cnt[stage]) data <= shifted;
                    stage <= stage + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign Out = data;

endmodule
